// File: rtl/mem_pkg.sv
// Shared helpers for the multi-port memory.
//   strb_w     : byte-strobe width for a given data width
//   merge_strb : replace the strobed bytes of a word (operates at MAX_DATA_W; callers
//                zero-extend their operands and truncate the result)
package mem_pkg;

    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

    function automatic int unsigned strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] merge_strb(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < MAX_STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Fixed-latency delay line for one read port's response.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid, in_payload  : response captured at the request edge
//   out_valid, out_payload: response LAT edges later; payload holds while out_valid=0
// Only valid bits and the final (externally visible) payload stage are reset.
module mem_rd_pipe #(
    parameter int unsigned W   = 8,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_payload,
    output logic         out_valid,
    output logic [W-1:0] out_payload
);

    logic         v_chain [LAT+1];
    logic [W-1:0] p_chain [LAT+1];

    assign v_chain[0] = in_valid;
    assign p_chain[0] = in_payload;

    for (genvar i = 0; i < LAT; i++) begin : g_stage
        logic         valid_q;
        logic [W-1:0] payload_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= v_chain[i];
            end
        end

        // Payload only advances with a valid entry, so the last stage holds the
        // previous response while the port is idle.
        if (i == LAT - 1) begin : g_last
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    payload_q <= '0;
                end else if (v_chain[i]) begin
                    payload_q <= p_chain[i];
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (v_chain[i]) begin
                    payload_q <= p_chain[i];
                end
            end
        end

        assign v_chain[i+1] = valid_q;
        assign p_chain[i+1] = payload_q;
    end

    assign out_valid   = v_chain[LAT];
    assign out_payload = p_chain[LAT];

endmodule

// File: rtl/mem_mp.sv
// Multi-read-port, single-write-port word memory with byte strobes, fixed read latency
// and tagged responses.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   rd_valid/rd_addr/rd_tag          : NRD packed read request ports
//   rd_resp/rd_resp_tag/rd_data/rd_err: NRD packed responses, RD_LAT cycles after request
//   wr_valid/wr_addr/wr_strb/wr_data : byte-strobed write port
//   wr_err                           : one-cycle pulse after an out-of-range write
// Reads in the same cycle as a write to the same word see the merged (new) data.
module mem_mp
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned NRD    = 2,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NRD-1:0]             rd_valid,
    input  logic [NRD*ADDR_W-1:0]      rd_addr,
    input  logic [NRD*TAG_W-1:0]       rd_tag,
    output logic [NRD-1:0]             rd_resp,
    output logic [NRD*TAG_W-1:0]       rd_resp_tag,
    output logic [NRD*DATA_W-1:0]      rd_data,
    output logic [NRD-1:0]             rd_err,
    input  logic                       wr_valid,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [strb_w(DATA_W)-1:0]  wr_strb,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_err
);

    localparam int unsigned STRB_W = strb_w(DATA_W);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One spare bit so DEPTH itself is representable; the full address is compared.
    localparam int unsigned CMP_W  = ((ADDR_W > IDX_W) ? ADDR_W : IDX_W) + 1;

    typedef struct packed {
        logic              err;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } rd_payload_t;

    function automatic logic [DATA_W-1:0] merge_w(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        return DATA_W'(merge_strb(MAX_DATA_W'(old_word), MAX_DATA_W'(new_word),
                                  MAX_STRB_W'(strb)));
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_in_range;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_err_q;

    assign wr_in_range = CMP_W'(wr_addr) < CMP_W'(DEPTH);
    assign wr_idx      = IDX_W'(wr_addr);

    always_ff @(posedge clk) begin
        if (wr_valid && wr_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_valid && !wr_in_range;
        end
    end

    assign wr_err = wr_err_q;

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic              in_range;
        logic              fwd_hit;
        rd_payload_t       pay_in;
        rd_payload_t       pay_out;
        logic              resp_valid;

        assign addr     = rd_addr[p*ADDR_W +: ADDR_W];
        assign in_range = CMP_W'(addr) < CMP_W'(DEPTH);
        assign fwd_hit  = wr_valid && wr_in_range && (wr_addr == addr);

        always_comb begin
            pay_in      = '0;
            pay_in.tag  = rd_tag[p*TAG_W +: TAG_W];
            pay_in.err  = !in_range;
            if (in_range) begin
                pay_in.data = mem_q[IDX_W'(addr)];
                if (fwd_hit) begin
                    pay_in.data = merge_w(pay_in.data, wr_data, wr_strb);
                end
            end
        end

        mem_rd_pipe #(
            .W   ($bits(rd_payload_t)),
            .LAT (RD_LAT)
        ) u_pipe (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (rd_valid[p]),
            .in_payload  (pay_in),
            .out_valid   (resp_valid),
            .out_payload (pay_out)
        );

        assign rd_resp[p]                      = resp_valid;
        assign rd_err[p]                       = resp_valid && pay_out.err;
        assign rd_resp_tag[p*TAG_W +: TAG_W]   = pay_out.tag;
        assign rd_data[p*DATA_W +: DATA_W]     = pay_out.data;
    end

endmodule

// File: tb/tb_mem_mp.sv
// Three instances (RD_LAT = 1, 3, 4) share one stimulus stream; a spec-level memory model
// queues the expected response per instance/port and a negedge monitor checks them.
module tb_mem_mp;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int NRD    = 2;
    localparam int DEPTH  = 1000;
    localparam int NDUT   = 3;

    typedef struct {
        int          due;
        logic        err;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [NRD-1:0]        rd_valid;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*TAG_W-1:0]  rd_tag;
    logic                  wr_valid;
    logic [ADDR_W-1:0]     wr_addr;
    logic [3:0]            wr_strb;
    logic [DATA_W-1:0]     wr_data;

    logic [NRD-1:0]        resp_w  [NDUT];
    logic [NRD*TAG_W-1:0]  rtag_w  [NDUT];
    logic [NRD*DATA_W-1:0] rdata_w [NDUT];
    logic [NRD-1:0]        rerr_w  [NDUT];
    logic                  werr_w  [NDUT];

    exp_t        exp_q [NDUT][NRD][$];
    int          werr_due [$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_data [NDUT][NRD];
    logic [3:0]  last_tag  [NDUT][NRD];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int L = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
        mem_mp #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .NRD    (NRD),
            .RD_LAT (L),
            .TAG_W  (TAG_W)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .rd_valid    (rd_valid),
            .rd_addr     (rd_addr),
            .rd_tag      (rd_tag),
            .rd_resp     (resp_w[k]),
            .rd_resp_tag (rtag_w[k]),
            .rd_data     (rdata_w[k]),
            .rd_err      (rerr_w[k]),
            .wr_valid    (wr_valid),
            .wr_addr     (wr_addr),
            .wr_strb     (wr_strb),
            .wr_data     (wr_data),
            .wr_err      (werr_w[k])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    task automatic chk(input bit ok, input string what, input int k, input int p,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s dut%0d port%0d: got %0h, expected %0h", what, k, p, act, exp);
        end
    endtask

    // Monitor: pops and compares whenever a response is presented.
    always @(negedge clk) begin
        logic exp_werr;
        exp_t e;
        exp_werr = 1'b0;
        if (werr_due.size() > 0 && werr_due[0] == cyc) begin
            exp_werr = 1'b1;
            void'(werr_due.pop_front());
        end
        for (int k = 0; k < NDUT; k++) begin
            for (int p = 0; p < NRD; p++) begin
                if (!rst_n) begin
                    chk(resp_w[k][p] === 1'b0, "reset_resp", k, p, 64'(resp_w[k][p]), 0);
                    chk(rdata_w[k][p*32 +: 32] === 32'h0, "reset_data", k, p,
                        64'(rdata_w[k][p*32 +: 32]), 0);
                    chk(rtag_w[k][p*4 +: 4] === 4'h0 && rerr_w[k][p] === 1'b0, "reset_tag_err",
                        k, p, {rtag_w[k][p*4 +: 4], 3'b0, rerr_w[k][p]}, 0);
                    last_data[k][p] = '0;
                    last_tag[k][p]  = '0;
                end else begin
                    if (exp_q[k][p].size() > 0 && exp_q[k][p][0].due < cyc) begin
                        e = exp_q[k][p].pop_front();
                        chk(1'b0, "missing_resp", k, p, 64'(cyc), 64'(e.due));
                    end
                    if (resp_w[k][p] === 1'b1) begin
                        if (exp_q[k][p].size() == 0) begin
                            chk(1'b0, "unexpected_resp", k, p, 64'(rtag_w[k][p*4 +: 4]), 0);
                        end else begin
                            e = exp_q[k][p].pop_front();
                            chk(e.due == cyc, "resp_cycle", k, p, 64'(cyc), 64'(e.due));
                            chk(rdata_w[k][p*32 +: 32] === e.data, "rd_data", k, p,
                                64'(rdata_w[k][p*32 +: 32]), 64'(e.data));
                            chk(rtag_w[k][p*4 +: 4] === e.tag, "rd_tag", k, p,
                                64'(rtag_w[k][p*4 +: 4]), 64'(e.tag));
                            chk(rerr_w[k][p] === e.err, "rd_err", k, p,
                                64'(rerr_w[k][p]), 64'(e.err));
                            last_data[k][p] = e.data;
                            last_tag[k][p]  = e.tag;
                        end
                    end else begin
                        chk(rdata_w[k][p*32 +: 32] === last_data[k][p] &&
                            rtag_w[k][p*4 +: 4] === last_tag[k][p] && rerr_w[k][p] === 1'b0,
                            "idle_hold", k, p,
                            {rtag_w[k][p*4 +: 4], rerr_w[k][p], rdata_w[k][p*32 +: 32]},
                            {last_tag[k][p], 1'b0, last_data[k][p]});
                    end
                end
            end
            chk(werr_w[k] === (rst_n ? exp_werr : 1'b0), "wr_err", k, 0,
                64'(werr_w[k]), 64'(rst_n ? exp_werr : 1'b0));
        end
    end

    // Drive one cycle of requests; expectations are computed before the model is updated.
    task automatic step(input logic [1:0] rv, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [3:0] t0, input logic [3:0] t1, input logic wv,
                        input logic [31:0] wa, input logic [3:0] ws, input logic [31:0] wd);
        logic [31:0] ra [2];
        logic [3:0]  rt [2];
        exp_t        e;
        ra[0] = a0; ra[1] = a1; rt[0] = t0; rt[1] = t1;
        rd_valid = rv;
        rd_addr  = {a1, a0};
        rd_tag   = {t1, t0};
        wr_valid = wv;
        wr_addr  = wa;
        wr_strb  = ws;
        wr_data  = wd;
        for (int p = 0; p < NRD; p++) begin
            if (rv[p]) begin
                e.tag = rt[p];
                if (ra[p] >= DEPTH) begin
                    e.err  = 1'b1;
                    e.data = '0;
                end else begin
                    e.err  = 1'b0;
                    e.data = model[ra[p]];
                    if (wv && wa == ra[p]) e.data = merge(e.data, wd, ws);
                end
                for (int k = 0; k < NDUT; k++) begin
                    e.due = cyc + lat_of(k);
                    exp_q[k][p].push_back(e);
                end
            end
        end
        if (wv) begin
            if (wa >= DEPTH) werr_due.push_back(cyc + 1);
            else model[wa] = merge(model[wa], wd, ws);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 0, 0, 0, 0, 1'b0, 0, 4'h0, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16) return 32'(r);
        if (r < 18) return 32'(DEPTH + $urandom_range(0, 50));
        return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    endfunction

    initial begin
        rst_n    = 1'b0;
        rd_valid = '0;
        rd_addr  = '0;
        rd_tag   = '0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_strb  = '0;
        wr_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        for (int a = 0; a < 16; a++) step(2'b00, 0, 0, 0, 0, 1'b1, 32'(a), 4'hF, $urandom);

        // Latency and tag return.
        step(2'b00, 0, 0, 0, 0, 1'b1, 5, 4'hF, 32'hDEAD_BEEF);
        step(2'b01, 5, 0, 4'h7, 0, 1'b0, 0, 4'h0, 0);
        idle(5);

        // Strobed write forwarded to both ports, then a later read.
        step(2'b00, 0, 0, 0, 0, 1'b1, 9, 4'hF, 32'h1122_3344);
        step(2'b11, 9, 9, 4'h1, 4'h2, 1'b1, 9, 4'b0101, 32'hAABB_CCDD);
        step(2'b01, 9, 0, 4'h3, 0, 1'b0, 0, 4'h0, 0);

        // Writes after the request edge must not leak into an in-flight response.
        step(2'b00, 0, 0, 0, 0, 1'b1, 2, 4'hF, 32'h1);
        step(2'b01, 2, 0, 4'h4, 0, 1'b0, 0, 4'h0, 0);
        step(2'b00, 0, 0, 0, 0, 1'b1, 2, 4'hF, 32'h2);
        step(2'b10, 0, 2, 0, 4'h5, 1'b0, 0, 4'h0, 0);

        // Out of range: no aliasing onto low words.
        step(2'b01, 1000, 0, 4'h6, 0, 1'b0, 0, 4'h0, 0);
        step(2'b00, 0, 0, 0, 0, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0);
        step(2'b00, 0, 0, 0, 0, 1'b1, 32'h0000_0405, 4'hF, 32'h0);
        step(2'b11, 5, 32'h3FF, 4'h8, 4'h9, 1'b0, 0, 4'h0, 0);
        step(2'b01, 1023, 0, 4'hA, 0, 1'b1, 1000, 4'h0, 0);
        idle(5);

        // Random back-to-back traffic.
        for (int i = 0; i < 96; i++) begin
            step(2'($urandom_range(0, 3)), rand_addr(), rand_addr(), 4'($urandom),
                 4'($urandom), 1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom);
        end
        idle(6);

        // Reset with reads in flight: none may emerge afterwards.
        step(2'b01, 5, 0, 4'h1, 0, 1'b0, 0, 4'h0, 0);
        step(2'b01, 3, 0, 4'h2, 0, 1'b0, 0, 4'h0, 0);
        step(2'b11, 4, 6, 4'h3, 4'hC, 1'b1, 32'hFFFF_0000, 4'hF, 0);
        rst_n    = 1'b0;
        rd_valid = '0;
        wr_valid = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            for (int p = 0; p < NRD; p++) exp_q[k][p].delete();
        end
        werr_due.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(6);
        step(2'b11, 5, 6, 4'hD, 4'hE, 1'b0, 0, 4'h0, 0);
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
